// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code flag unit: flag bit positions
// within the {Z,V,C,N} vector and the branch-condition encodings.
package cc_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [3:0] {
    COND_AL = 4'h0,
    COND_EQ = 4'h1,
    COND_NE = 4'h2,
    COND_CS = 4'h3,
    COND_CC = 4'h4,
    COND_MI = 4'h5,
    COND_PL = 4'h6,
    COND_VS = 4'h7,
    COND_VC = 4'h8,
    COND_HI = 4'h9,
    COND_LS = 4'hA,
    COND_GE = 4'hB,
    COND_LT = 4'hC,
    COND_GT = 4'hD,
    COND_LE = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational branch-condition decoder: selects one predicate of the
// {Z,V,C,N} flags according to the 4-bit condition code.
module cc_cond_eval
  import cc_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic z, v, c, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];

  // Decode the condition selector into a single taken bit.
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_flag_unit.sv
// Condition-code flag register with branch evaluation and an optional
// LIFO flag stack. Define CC_STACK_EN to build the stack in; without it
// PUSH/POP are ignored and the stack status outputs are constant.
//
// Result protocol: BR_VALID is a one-cycle pulse in the cycle after each
// edge that sampled BR_REQ=1; there is no ready, the result must be taken
// that cycle. TAKEN is only meaningful with BR_VALID and is 0 otherwise.
module cc_flag_unit
  import cc_pkg::*;
#(
  parameter int STK_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Z_in,
  input  logic       V_in,
  input  logic       C_in,
  input  logic       N_in,
  input  logic       CC_WE,
  input  logic       BR_REQ,
  input  logic [3:0] COND,
  input  logic       PUSH,
  input  logic       POP,
  output logic       Z,
  output logic       V,
  output logic       C,
  output logic       N,
  output logic       Pre_C,
  output logic       BR_VALID,
  output logic       TAKEN,
  output logic       STK_FULL,
  output logic       STK_EMPTY,
  output logic       STK_ERR
);

  logic [3:0] flags;
  logic [3:0] flags_nxt;
  logic [3:0] cc_in;
  logic [3:0] eval_flags;
  logic       taken_comb;
  logic       br_valid_q;
  logic       taken_q;

  assign cc_in = {Z_in, V_in, C_in, N_in};

  // A same-edge flag write is forwarded so the branch sees the new flags.
  assign eval_flags = CC_WE ? cc_in : flags;

  cc_cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (COND),
    .taken (taken_comb)
  );

  // Register the evaluation result one cycle after the request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      br_valid_q <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      br_valid_q <= BR_REQ;
      taken_q    <= BR_REQ & taken_comb;
    end
  end

  // Flag register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) flags <= 4'b0000;
    else        flags <= flags_nxt;
  end

`ifdef CC_STACK_EN
  localparam int CW = $clog2(STK_DEPTH + 1);
  localparam int IW = $clog2(STK_DEPTH);

  logic [3:0]    stk [STK_DEPTH];
  logic [CW-1:0] count;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          push_only;
  logic          pop_only;
  logic          push_ok;
  logic          pop_ok;
  logic          stk_err_q;

  assign push_only = PUSH & ~POP;
  assign pop_only  = POP & ~PUSH;
  assign STK_FULL  = (count == CW'(STK_DEPTH));
  assign STK_EMPTY = (count == '0);
  assign push_ok   = push_only & ~STK_FULL;
  assign pop_ok    = pop_only & ~STK_EMPTY;
  assign wr_idx    = IW'(count);
  assign top_idx   = IW'(count - CW'(1));
  assign STK_ERR   = stk_err_q;

  // Stack depth counter and sticky overflow/underflow error.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count     <= '0;
      stk_err_q <= 1'b0;
    end else begin
      if (push_ok)     count <= count + CW'(1);
      else if (pop_ok) count <= count - CW'(1);
      if ((push_only & STK_FULL) | (pop_only & STK_EMPTY)) stk_err_q <= 1'b1;
    end
  end

  // Stack storage; pushes save the flags as they were before this edge.
  always_ff @(posedge CLK) begin
    if (push_ok) stk[wr_idx] <= flags;
  end

  // Next flags: a restore from the stack wins over an ALU write.
  always_comb begin
    flags_nxt = flags;
    if (pop_ok)     flags_nxt = stk[top_idx];
    else if (CC_WE) flags_nxt = cc_in;
  end
`else
  logic unused_stk;

  assign unused_stk = PUSH ^ POP;
  assign STK_FULL   = 1'b0;
  assign STK_EMPTY  = 1'b1;
  assign STK_ERR    = 1'b0;

  // Next flags: only ALU writes exist without the stack.
  always_comb begin
    flags_nxt = flags;
    if (CC_WE) flags_nxt = cc_in;
  end
`endif

  assign Z        = flags[FLAG_Z];
  assign V        = flags[FLAG_V];
  assign C        = flags[FLAG_C];
  assign N        = flags[FLAG_N];
  assign Pre_C    = flags[FLAG_C];
  assign BR_VALID = br_valid_q;
  assign TAKEN    = taken_q;

endmodule

// File: tb/tb_cc_flag_unit.sv
// Bench for cc_flag_unit: table of condition vectors plus hand-written
// sequences for carry feedback, back-to-back requests, the flag stack
// (or its absence without CC_STACK_EN) and reset during an evaluation.
module tb_cc_flag_unit;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       Z_in, V_in, C_in, N_in;
  logic       CC_WE, BR_REQ, PUSH, POP;
  logic [3:0] COND;
  logic       Z, V, C, N, Pre_C, BR_VALID, TAKEN;
  logic       STK_FULL, STK_EMPTY, STK_ERR;
  logic [3:0] flags_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] flags;  // {Z,V,C,N}
    logic [3:0] cond;
    logic       fwd;    // write flags on the request edge
    logic       exp;
  } vec_t;

  vec_t       vtab[$];
  logic [3:0] exp_q[$];

  always #5 CLK = ~CLK;

  cc_flag_unit #(.STK_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Z_in(Z_in), .V_in(V_in), .C_in(C_in), .N_in(N_in),
    .CC_WE(CC_WE), .BR_REQ(BR_REQ), .COND(COND),
    .PUSH(PUSH), .POP(POP),
    .Z(Z), .V(V), .C(C), .N(N), .Pre_C(Pre_C),
    .BR_VALID(BR_VALID), .TAKEN(TAKEN),
    .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .STK_ERR(STK_ERR)
  );

  assign flags_o = {Z, V, C, N};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic [3:0] f);
    {Z_in, V_in, C_in, N_in} = f;
  endtask

  task automatic idle();
    set_in(4'b0000);
    CC_WE = 1'b0; BR_REQ = 1'b0; COND = 4'h0; PUSH = 1'b0; POP = 1'b0;
  endtask

  task automatic load(input logic [3:0] f);
    set_in(f); CC_WE = 1'b1;
    tick();
    CC_WE = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " flags"}, flags_o, 4'b0000);
    check({tag, " pre_c"}, Pre_C, 1'b0);
    check({tag, " br_valid"}, BR_VALID, 1'b0);
    check({tag, " taken"}, TAKEN, 1'b0);
    check({tag, " stk_err"}, STK_ERR, 1'b0);
    check({tag, " stk_full"}, STK_FULL, 1'b0);
    check({tag, " stk_empty"}, STK_EMPTY, 1'b1);
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] seqv [4];
    logic [3:0] e;

    // ---- reset -------------------------------------------------------------
    idle();
    RST_N = 1'b0;
    #12;
    check_reset_outputs("reset");
    tick();
    RST_N = 1'b1;
    tick();
    check("idle br_valid", BR_VALID, 1'b0);

    // ---- condition table ---------------------------------------------------
    // 1234+2345=3579: Z,V,C,N = 0,0,0,0
    vtab.push_back('{4'b0000, 4'h1, 1'b0, 1'b0});
    vtab.push_back('{4'b0000, 4'h2, 1'b0, 1'b1});
    vtab.push_back('{4'b0000, 4'h0, 1'b0, 1'b1});
    vtab.push_back('{4'b1111, 4'hF, 1'b0, 1'b0});
    vtab.push_back('{4'b1000, 4'h1, 1'b0, 1'b1});
    vtab.push_back('{4'b0010, 4'h3, 1'b0, 1'b1});
    vtab.push_back('{4'b0010, 4'h4, 1'b0, 1'b0});
    vtab.push_back('{4'b0001, 4'h5, 1'b0, 1'b1});
    vtab.push_back('{4'b0001, 4'h6, 1'b1, 1'b0});
    vtab.push_back('{4'b0100, 4'h7, 1'b0, 1'b1});
    vtab.push_back('{4'b0100, 4'h8, 1'b1, 1'b0});
    vtab.push_back('{4'b0010, 4'h9, 1'b0, 1'b1});
    vtab.push_back('{4'b1010, 4'h9, 1'b1, 1'b0});
    vtab.push_back('{4'b1010, 4'hA, 1'b0, 1'b1});
    vtab.push_back('{4'b0010, 4'hA, 1'b0, 1'b0});
    vtab.push_back('{4'b0101, 4'hB, 1'b0, 1'b1});
    vtab.push_back('{4'b0001, 4'hB, 1'b1, 1'b0});
    // 1234-2345=EEEF: N=1, V=0, forwarded into LT on the same edge
    vtab.push_back('{4'b0001, 4'hC, 1'b1, 1'b1});
    vtab.push_back('{4'b0101, 4'hC, 1'b0, 1'b0});
    vtab.push_back('{4'b0101, 4'hD, 1'b0, 1'b1});
    vtab.push_back('{4'b1101, 4'hD, 1'b1, 1'b0});
    vtab.push_back('{4'b0001, 4'hE, 1'b0, 1'b1});
    vtab.push_back('{4'b0000, 4'hE, 1'b1, 1'b0});
    vtab.push_back('{4'b0110, 4'hE, 1'b0, 1'b1});

    foreach (vtab[i]) begin
      // Registered flags start as the complement so the wrong source shows.
      if (vtab[i].fwd) begin
        load(~vtab[i].flags);
        set_in(vtab[i].flags); CC_WE = 1'b1;
      end else begin
        load(vtab[i].flags);
        set_in(~vtab[i].flags); CC_WE = 1'b0;
      end
      BR_REQ = 1'b1; COND = vtab[i].cond;
      tick();
      idle();
      check($sformatf("vec%0d br_valid", i), BR_VALID, 1'b1);
      check($sformatf("vec%0d taken", i), TAKEN, vtab[i].exp);
      check($sformatf("vec%0d flags", i), flags_o, vtab[i].flags);
      tick();
      check($sformatf("vec%0d valid_drop", i), BR_VALID, 1'b0);
      check($sformatf("vec%0d taken_drop", i), TAKEN, 1'b0);
    end

    // ---- back-to-back requests ---------------------------------------------
    load(4'b1000);
    BR_REQ = 1'b1; COND = 4'h1;
    tick();
    check("b2b first valid", BR_VALID, 1'b1);
    check("b2b first taken", TAKEN, 1'b1);
    COND = 4'h2;
    tick();
    check("b2b second valid", BR_VALID, 1'b1);
    check("b2b second taken", TAKEN, 1'b0);
    BR_REQ = 1'b0;
    tick();
    check("b2b end valid", BR_VALID, 1'b0);

    // ---- carry feedback ----------------------------------------------------
    load(4'b0000);
    check("pre_c low", Pre_C, 1'b0);
    set_in(4'b0010); CC_WE = 1'b1;
    check("pre_c before edge", Pre_C, 1'b0);
    tick();
    idle();
    check("pre_c set", Pre_C, 1'b1);
    tick(); tick();
    check("pre_c held", Pre_C, 1'b1);
    load(4'b0000);
    check("pre_c cleared", Pre_C, 1'b0);

`ifdef CC_STACK_EN
    // ---- pop on empty ------------------------------------------------------
    load(4'b1001);
    POP = 1'b1;
    tick();
    POP = 1'b0;
    check("pop_empty flags", flags_o, 4'b1001);
    check("pop_empty err", STK_ERR, 1'b1);
    check("pop_empty empty", STK_EMPTY, 1'b1);
    tick();
    check("err sticky", STK_ERR, 1'b1);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("stk reset");
    tick();
    RST_N = 1'b1;

    // ---- fill, overflow, LIFO drain ----------------------------------------
    seqv[0] = 4'h2; seqv[1] = 4'h4; seqv[2] = 4'h8; seqv[3] = 4'hF;
    cur = 4'h1;
    load(cur);
    for (int i = 0; i < 4; i++) begin
      // Each push saves the old flags while the same edge writes new ones.
      set_in(seqv[i]); CC_WE = 1'b1; PUSH = 1'b1;
      exp_q.push_back(cur);
      tick();
      cur = seqv[i];
      check($sformatf("push%0d flags", i), flags_o, cur);
    end
    idle();
    check("full after 4", STK_FULL, 1'b1);
    check("not empty after 4", STK_EMPTY, 1'b0);
    check("no err after 4", STK_ERR, 1'b0);
    PUSH = 1'b1;
    tick();
    PUSH = 1'b0;
    check("overflow err", STK_ERR, 1'b1);
    check("overflow full", STK_FULL, 1'b1);
    check("overflow flags", flags_o, 4'hF);
    for (int i = 0; i < 4; i++) begin
      // Pop overrides a same-edge ALU write.
      POP = 1'b1; set_in(4'h6); CC_WE = 1'b1;
      tick();
      e = exp_q.pop_back();
      check($sformatf("pop%0d flags", i), flags_o, e);
      check($sformatf("pop%0d full", i), STK_FULL, 1'b0);
      check($sformatf("pop%0d empty", i), STK_EMPTY, (i == 3) ? 1'b1 : 1'b0);
    end
    idle();

    // ---- push and pop together ---------------------------------------------
    load(4'h3);
    PUSH = 1'b1;
    tick();
    PUSH = 1'b0;
    check("single push empty", STK_EMPTY, 1'b0);
    PUSH = 1'b1; POP = 1'b1; set_in(4'hA); CC_WE = 1'b1;
    tick();
    idle();
    check("push_pop flags", flags_o, 4'hA);
    check("push_pop empty", STK_EMPTY, 1'b0);
    check("push_pop full", STK_FULL, 1'b0);
    POP = 1'b1;
    tick();
    POP = 1'b0;
    check("push_pop restore", flags_o, 4'h3);
    check("push_pop drained", STK_EMPTY, 1'b1);
`else
    // ---- stack absent ------------------------------------------------------
    load(4'h5);
    PUSH = 1'b1;
    tick();
    PUSH = 1'b0; POP = 1'b1;
    tick();
    POP = 1'b0;
    check("nostk flags", flags_o, 4'h5);
    check("nostk empty", STK_EMPTY, 1'b1);
    check("nostk full", STK_FULL, 1'b0);
    check("nostk err", STK_ERR, 1'b0);
    POP = 1'b1;
    tick(); tick();
    POP = 1'b0;
    check("nostk pop flags", flags_o, 4'h5);
    check("nostk pop err", STK_ERR, 1'b0);
`endif

    // ---- reset with an evaluation in flight --------------------------------
    load(4'hF);
    BR_REQ = 1'b1; COND = 4'h0;
    tick();
    check("inflight valid", BR_VALID, 1'b1);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("mid reset");
    tick();
    check("held reset valid", BR_VALID, 1'b0);
    BR_REQ = 1'b0;
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post reset valid%0d", i), BR_VALID, 1'b0);
      check($sformatf("post reset taken%0d", i), TAKEN, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_flag_unit.md
CC_FLAG_UNIT -- requirements
Module: cc_flag_unit

Interface
REQ-001 SHALL have parameter STK_DEPTH, default 4, giving the number of flag-stack entries (2..16).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Z_in/V_in/C_in/N_in, input, 1 bit each: condition codes from the ALU.
REQ-005 SHALL have port CC_WE, input, 1 bit: latch the *_in flags at the clock edge.
REQ-006 SHALL have port BR_REQ, input, 1 bit: request a branch-condition evaluation.
REQ-007 SHALL have port COND, input, 4 bits: condition selector for BR_REQ.
REQ-008 SHALL have port PUSH and POP, input, 1 bit each: save or restore the flag set.
REQ-009 SHALL have port Z/V/C/N, output, 1 bit each: registered flags.
REQ-010 SHALL have port Pre_C, output, 1 bit: equal to the registered C, fed back to the ALU carry-in.
REQ-011 SHALL have port BR_VALID and TAKEN, output, 1 bit each: the evaluation result.
REQ-012 SHALL have port STK_FULL, STK_EMPTY and STK_ERR, output, 1 bit each: stack status.

Function
REQ-013 SHALL load {Z,V,C,N} from *_in on an edge with CC_WE=1; otherwise the flags hold.
REQ-014 SHALL assert BR_VALID exactly one cycle after each edge with BR_REQ=1, for one cycle; back-to-back requests give back-to-back results.
REQ-015 SHALL compute TAKEN from the flags visible at the request edge; if CC_WE=1 on the same edge, the incoming *_in flags SHALL be used (forwarding).
REQ-016 SHALL decode COND as follows:
- 0 AL=1; 1 EQ=Z; 2 NE=~Z; 3 CS=C; 4 CC=~C; 5 MI=N; 6 PL=~N; 7 VS=V; 8 VC=~V
- 9 HI=C&~Z; A LS=~C|Z; B GE=(N==V); C LT=(N!=V); D GT=~Z&(N==V); E LE=Z|(N!=V); F NV=0
REQ-017 SHALL hold TAKEN at 0 whenever BR_VALID=0.
REQ-018 SHALL, on PUSH only, store the current (pre-CC_WE) flags; a same-edge CC_WE still updates the register.
REQ-019 SHALL, on POP only, restore the top entry into the flags; POP SHALL override a same-edge CC_WE.
REQ-020 SHALL treat PUSH and POP on the same edge as a no-op on the stack and flags, with CC_WE still honoured.
REQ-021 SHALL ignore PUSH when full and POP when empty, and set the sticky STK_ERR, which clears only on reset.
REQ-022 SHALL drive STK_FULL = (count==STK_DEPTH) and STK_EMPTY = (count==0), both combinational from the count.

Reset
REQ-023 SHALL, while RST_N=0, asynchronously clear Z, V, C, N, Pre_C, BR_VALID, TAKEN, STK_ERR and the stack count; STK_EMPTY=1 and STK_FULL=0.
REQ-024 SHALL drop any evaluation in flight when reset is asserted; no BR_VALID appears after reset is released.

Configuration
REQ-025 SHALL compile the flag stack in only when CC_STACK_EN is defined.
REQ-026 SHALL, without CC_STACK_EN, ignore PUSH and POP and tie STK_EMPTY=1, STK_FULL=0 and STK_ERR=0, with no stack storage.

Structure
REQ-027 SHALL take the COND encodings (AL..NV) and the flag bit indices {Z,V,C,N}=[3:0] from shared package cc_pkg.
REQ-028 SHALL put the combinational COND decoder in sub-module cc_cond_eval (inputs: flags and COND; output: taken).

Verification
REQ-029 SHALL cover: reset, then CC_WE with Z,V,C,N_in=0,0,0,0 (ALU 16'h1234+16'h2345=16'h3579) and BR_REQ COND=1 on the next edge -> BR_VALID=1 one cycle later, TAKEN=0; COND=2 -> TAKEN=1.
REQ-030 SHALL cover: the same edge with CC_WE (N_in=1, V_in=0, from 16'h1234-16'h2345=16'hEEEF) and BR_REQ COND=C -> TAKEN=1 via forwarding.
REQ-031 SHALL cover: CC_WE with C_in=1 -> Pre_C=1 from the next cycle, until the next CC_WE with C_in=0.
REQ-032 SHALL cover: four PUSHes of distinct flag sets, then a fifth -> STK_FULL=1, STK_ERR=1, count stays 4; four POPs restore in LIFO order; STK_EMPTY=1 afterwards.
REQ-033 SHALL cover: POP when empty -> flags unchanged, STK_ERR=1; PUSH and POP on the same edge -> count unchanged.
REQ-034 SHALL cover: RST_N pulsed low mid-sequence with BR_REQ pending -> all outputs 0 immediately and no BR_VALID afterwards; and, built without CC_STACK_EN, PUSH/POP have no effect and STK_EMPTY=1.
